// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: line-state encodings and the default bit period.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_tx_pkg;

   // 50 MHz core clock at 115200 baud
   localparam int UART_DEFAULT_CLKS_PER_BIT = 434;

   typedef enum logic [2:0] {
      UART_IDLE   = 3'd0,
      UART_START  = 3'd1,
      UART_DATA   = 3'd2,
      UART_PARITY = 3'd3,
      UART_STOP   = 3'd4
   } uart_state_t;

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake into the UART transmitter (valid/ready).
// Latency: n/a (bundle of wires).
// Backpressure: tx_ready low means the byte is not taken; there is no queue.
// Signals: tx_data (DATA_BITS), tx_valid (master->slave), tx_ready (slave->master).
interface uart_tx_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] tx_data;
   logic                 tx_valid;
   logic                 tx_ready;

   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled, ticks bit_end_o on the last count.
// Latency: bit_end_o is combinational from the count; clear takes effect on the next edge.
// Backpressure: none; clear wins over enable.
// Ports: clk_i, rst_n_i, clr_i (restart period), en_i (count), bit_end_o (last cycle of a bit).
module uart_tx_baud_gen #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic clr_i,
   input  logic en_i,
   output logic bit_end_o
);

   localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

   logic [CW-1:0] cnt;

   assign bit_end_o = en_i && (cnt == CW'(CLKS_PER_BIT - 1));

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt <= '0;
      end else if (clr_i) begin
         cnt <= '0;
      end else if (en_i) begin
         cnt <= bit_end_o ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data LSB first, optional parity, 1 or 2 stop bits on tx_o.
// Latency: tx_o goes low the cycle after accept; tx_done_o pulses when the last stop bit ends.
// Backpressure: tx_ready low for the whole frame; bytes offered meanwhile are ignored, not queued.
// Ports: clk_i, rst_n_i (async, active low), tx_if (slave: data/valid/ready), tx_o (registered line),
//        tx_busy_o (frame in progress), tx_done_o (one-cycle end-of-frame pulse).
module uart_tx
   import uart_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
   parameter int DATA_BITS    = 8,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic     clk_i,
   input  logic     rst_n_i,
   uart_tx_if.slave tx_if,
   output logic     tx_o,
   output logic     tx_busy_o,
   output logic     tx_done_o
);

   if (CLKS_PER_BIT < 2) begin : g_chk_cpb
      $error("uart_tx: CLKS_PER_BIT must be >= 2");
   end
   if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_chk_db
      $error("uart_tx: DATA_BITS must be 5..8");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_sb
      $error("uart_tx: STOP_BITS must be 1 or 2");
   end

   localparam int BW = $clog2(DATA_BITS);

   uart_state_t          state;
   logic [DATA_BITS-1:0] shreg;
   logic [BW-1:0]        bit_cnt;
   logic                 parity_q;
   logic                 stop_cnt;
   logic                 ready_q;
   logic                 accept;
   logic                 bit_end;

   assign tx_if.tx_ready = ready_q;
   assign accept         = tx_if.tx_valid & ready_q;

   // Cleared on accept so the start bit gets a full period.
   uart_tx_baud_gen #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .clr_i     (accept),
      .en_i      (state != UART_IDLE),
      .bit_end_o (bit_end)
   );

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state     <= UART_IDLE;
         shreg     <= '0;
         bit_cnt   <= '0;
         parity_q  <= 1'b0;
         stop_cnt  <= 1'b0;
         ready_q   <= 1'b1;
         tx_o      <= 1'b1;
         tx_busy_o <= 1'b0;
         tx_done_o <= 1'b0;
      end else begin
         tx_done_o <= 1'b0;
         case (state)
            UART_IDLE: begin
               if (accept) begin
                  shreg     <= tx_if.tx_data;
                  parity_q  <= (^tx_if.tx_data) ^ PARITY_ODD[0];
                  bit_cnt   <= '0;
                  stop_cnt  <= 1'b0;
                  ready_q   <= 1'b0;
                  tx_busy_o <= 1'b1;
                  tx_o      <= 1'b0;
                  state     <= UART_START;
               end
            end
            UART_START: begin
               if (bit_end) begin
                  tx_o  <= shreg[0];
                  state <= UART_DATA;
               end
            end
            UART_DATA: begin
               if (bit_end) begin
                  if (bit_cnt == BW'(DATA_BITS - 1)) begin
                     if (PARITY_EN != 0) begin
                        tx_o  <= parity_q;
                        state <= UART_PARITY;
                     end else begin
                        tx_o  <= 1'b1;
                        state <= UART_STOP;
                     end
                  end else begin
                     // Next bit is shreg[1]; drive it now so tx_o stays a pure flop output.
                     shreg   <= shreg >> 1;
                     tx_o    <= shreg[1];
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
            UART_PARITY: begin
               if (bit_end) begin
                  tx_o  <= 1'b1;
                  state <= UART_STOP;
               end
            end
            UART_STOP: begin
               if (bit_end) begin
                  if (stop_cnt == 1'(STOP_BITS - 1)) begin
                     ready_q   <= 1'b1;
                     tx_busy_o <= 1'b0;
                     tx_done_o <= 1'b1;
                     state     <= UART_IDLE;
                  end else begin
                     stop_cnt <= 1'b1;
                  end
               end
            end
            default: begin
               tx_o      <= 1'b1;
               ready_q   <= 1'b1;
               tx_busy_o <= 1'b0;
               state     <= UART_IDLE;
            end
         endcase
      end
   end

endmodule
